// File: rtl/joystick_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : joystick_pkg                                           |
// | Description : Shared state encoding and constants for the joystick   |
// |               input conditioning block. The CAL state exists only    |
// |               when JOYSTICK_CAL_EN is defined.                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package joystick_pkg;

  localparam int NEUTRAL          = 512;
  localparam int CAL_SAMPLES      = 8;
  localparam int AVG_SAMPLES      = 4;
  localparam int DEADZONE_DEFAULT = 60;
  localparam int DEBOUNCE_DEFAULT = 3;

`ifdef JOYSTICK_CAL_EN
  typedef enum logic [1:0] {
    ST_CAL = 2'd0,
    ST_ACC = 2'd1,
    ST_OUT = 2'd2
  } state_t;

  localparam state_t ST_RESET = ST_CAL;
`else
  typedef enum logic [1:0] {
    ST_ACC = 2'd1,
    ST_OUT = 2'd2
  } state_t;

  localparam state_t ST_RESET = ST_ACC;
`endif

endpackage : joystick_pkg
`default_nettype wire

// File: rtl/joystick_axis.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : joystick_axis                                          |
// | Description : One joystick axis: sample accumulator, centre          |
// |               register, offset, deadzone and 0..1023 clamp.          |
// |               JOYSTICK_CAL_EN enables the calibrated centre;         |
// |               otherwise the centre is fixed at NEUTRAL.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module joystick_axis
  import joystick_pkg::*;
#(
  parameter int DEADZONE = DEADZONE_DEFAULT
) (
  input  logic       clk_30hz,
  input  logic       RST,
  input  logic [9:0] sample,
  input  logic       acc_en,
  input  logic       cal_last,
  input  logic       out_en,
  output logic [9:0] pos
);

`ifdef JOYSTICK_CAL_EN
  // Eight 10-bit samples need 13 bits during calibration.
  localparam int ACC_W = 13;
`else
  localparam int ACC_W = 12;
`endif

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_sum;
  logic [9:0]       w_centre;
  logic [9:0]       w_avg;
  logic [11:0]      w_off;
  logic [11:0]      w_mag;
  logic [11:0]      w_shift;
  logic [9:0]       w_result;

  assign w_sum = r_acc + {{(ACC_W-10){1'b0}}, sample};

  // Running sum of accepted samples; cleared after calibration and after each output.
  always_ff @(posedge clk_30hz) begin
    if (RST) begin
      r_acc <= '0;
    end else if (cal_last || out_en) begin
      r_acc <= '0;
    end else if (acc_en) begin
      r_acc <= w_sum;
    end
  end

`ifdef JOYSTICK_CAL_EN
  logic [9:0] r_centre;

  // Centre captured as the mean of the calibration samples, including the last one.
  always_ff @(posedge clk_30hz) begin
    if (RST) begin
      r_centre <= 10'(NEUTRAL);
    end else if (cal_last) begin
      r_centre <= w_sum[12:3];
    end
  end

  assign w_centre = r_centre;
`else
  assign w_centre = 10'(NEUTRAL);
`endif

  // The four-sample average always fits in 12 bits, so bits [11:2] are the mean.
  assign w_avg   = r_acc[11:2];
  assign w_off   = {2'b00, w_avg} - {2'b00, w_centre};
  assign w_mag   = w_off[11] ? (~w_off + 12'd1) : w_off;
  assign w_shift = 12'(NEUTRAL) + w_off;

  // Deadzone snaps to neutral; otherwise clamp negative and >1023 results.
  always_comb begin
    w_result = 10'(NEUTRAL);
    if (w_mag > 12'(DEADZONE)) begin
      if (w_shift[11]) begin
        w_result = 10'd0;
      end else if (w_shift[10]) begin
        w_result = 10'd1023;
      end else begin
        w_result = w_shift[9:0];
      end
    end
  end

  // Position register only changes in the OUT cycle and holds otherwise.
  always_ff @(posedge clk_30hz) begin
    if (RST) begin
      pos <= 10'(NEUTRAL);
    end else if (out_en) begin
      pos <= w_result;
    end
  end

endmodule : joystick_axis
`default_nettype wire

// File: rtl/joystick_input.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : joystick_input                                         |
// | Description : Joystick front end: sample handshake FSM (CAL/ACC/OUT),|
// |               two conditioned axes and a fire-button debouncer.      |
// |               Macro JOYSTICK_CAL_EN enables centre calibration.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module joystick_input
  import joystick_pkg::*;
#(
  parameter int DEADZONE = DEADZONE_DEFAULT,
  parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
  input  logic       clk_30hz,
  input  logic       RST,
  input  logic       sample_valid,
  input  logic [9:0] sample_x,
  input  logic [9:0] sample_y,
  output logic       sample_ready,
  input  logic       btn_raw,
  output logic [9:0] xPosData,
  output logic [9:0] yPosData,
  output logic       pos_valid,
  output logic       fire,
  output logic       cal_done
);

  localparam int DBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_xfer_cnt;
  logic [2:0] w_xfer_cnt_nxt;
  logic       w_xfer;
  logic       w_acc_en;
  logic       w_cal_last;
  logic       w_out_en;

  logic           r_btn_state;
  logic [DBW-1:0] r_db_cnt;

  assign sample_ready = (r_state != ST_OUT);
  assign w_xfer       = sample_valid & sample_ready;

  // State and transfer counter registers.
  always_ff @(posedge clk_30hz) begin
    if (RST) begin
      r_state    <= ST_RESET;
      r_xfer_cnt <= 3'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_xfer_cnt <= w_xfer_cnt_nxt;
    end
  end

  // Next-state logic and per-cycle strobes to the axis datapaths.
  always_comb begin
    w_state_nxt    = r_state;
    w_xfer_cnt_nxt = r_xfer_cnt;
    w_acc_en       = 1'b0;
    w_cal_last     = 1'b0;
    w_out_en       = 1'b0;
    case (r_state)
`ifdef JOYSTICK_CAL_EN
      ST_CAL: begin
        if (w_xfer) begin
          w_acc_en = 1'b1;
          if (r_xfer_cnt == 3'(CAL_SAMPLES - 1)) begin
            w_cal_last     = 1'b1;
            w_xfer_cnt_nxt = 3'd0;
            w_state_nxt    = ST_ACC;
          end else begin
            w_xfer_cnt_nxt = r_xfer_cnt + 3'd1;
          end
        end
      end
`endif
      ST_ACC: begin
        if (w_xfer) begin
          w_acc_en = 1'b1;
          if (r_xfer_cnt == 3'(AVG_SAMPLES - 1)) begin
            w_xfer_cnt_nxt = 3'd0;
            w_state_nxt    = ST_OUT;
          end else begin
            w_xfer_cnt_nxt = r_xfer_cnt + 3'd1;
          end
        end
      end
      ST_OUT: begin
        w_out_en    = 1'b1;
        w_state_nxt = ST_ACC;
      end
      default: begin
        w_xfer_cnt_nxt = 3'd0;
        w_state_nxt    = ST_RESET;
      end
    endcase
  end

  // Result strobe lines up with the cycle the new positions become visible.
  always_ff @(posedge clk_30hz) begin
    if (RST) begin
      pos_valid <= 1'b0;
    end else begin
      pos_valid <= w_out_en;
    end
  end

`ifdef JOYSTICK_CAL_EN
  // Calibration flag set by the final calibration transfer.
  always_ff @(posedge clk_30hz) begin
    if (RST) begin
      cal_done <= 1'b0;
    end else if (w_cal_last) begin
      cal_done <= 1'b1;
    end
  end
`else
  // With a fixed centre there is nothing to calibrate; report done right after reset.
  always_ff @(posedge clk_30hz) begin
    if (RST) begin
      cal_done <= 1'b0;
    end else begin
      cal_done <= 1'b1;
    end
  end
`endif

  // Debouncer: state flips after DEBOUNCE consecutive disagreeing samples; fire marks a press.
  always_ff @(posedge clk_30hz) begin
    if (RST) begin
      r_btn_state <= 1'b0;
      r_db_cnt    <= '0;
      fire        <= 1'b0;
    end else begin
      fire <= 1'b0;
      if (btn_raw == r_btn_state) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DBW'(DEBOUNCE - 1)) begin
        r_btn_state <= ~r_btn_state;
        r_db_cnt    <= '0;
        fire        <= ~r_btn_state;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  joystick_axis #(
    .DEADZONE (DEADZONE)
  ) u_axis_x (
    .clk_30hz (clk_30hz),
    .RST      (RST),
    .sample   (sample_x),
    .acc_en   (w_acc_en),
    .cal_last (w_cal_last),
    .out_en   (w_out_en),
    .pos      (xPosData)
  );

  joystick_axis #(
    .DEADZONE (DEADZONE)
  ) u_axis_y (
    .clk_30hz (clk_30hz),
    .RST      (RST),
    .sample   (sample_y),
    .acc_en   (w_acc_en),
    .cal_last (w_cal_last),
    .out_en   (w_out_en),
    .pos      (yPosData)
  );

endmodule : joystick_input
`default_nettype wire

// File: tb/tb_joystick_input.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_joystick_input                                      |
// | Description : Scoreboard bench for joystick_input. Expected          |
// |               positions are queued by the stimulus and popped by a   |
// |               monitor on every pos_valid. Covers both settings of    |
// |               JOYSTICK_CAL_EN.                                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_joystick_input;

  logic       clk_30hz = 1'b0;
  logic       RST;
  logic       sample_valid;
  logic [9:0] sample_x;
  logic [9:0] sample_y;
  logic       sample_ready;
  logic       btn_raw;
  logic [9:0] xPosData;
  logic [9:0] yPosData;
  logic       pos_valid;
  logic       fire;
  logic       cal_done;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } pos_t;

  typedef struct {
    int cx;
    int cy;
    int x;
    int y;
    int ex;
    int ey;
  } vec_t;

  localparam int NVEC = 6;

  pos_t exp_q[$];
  vec_t vecs[NVEC];
  int   checks = 0;
  int   errors = 0;

  joystick_input dut (
    .clk_30hz     (clk_30hz),
    .RST          (RST),
    .sample_valid (sample_valid),
    .sample_x     (sample_x),
    .sample_y     (sample_y),
    .sample_ready (sample_ready),
    .btn_raw      (btn_raw),
    .xPosData     (xPosData),
    .yPosData     (yPosData),
    .pos_valid    (pos_valid),
    .fire         (fire),
    .cal_done     (cal_done)
  );

  always #5 clk_30hz = ~clk_30hz;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: every pos_valid must match the oldest queued expectation.
  always @(negedge clk_30hz) begin
    if (pos_valid) begin
      if (exp_q.size() == 0) begin
        check("pos_valid_unexpected", 1, 0);
      end else begin
        pos_t e;
        e = exp_q.pop_front();
        check("xPosData", int'(xPosData), int'(e.x));
        check("yPosData", int'(yPosData), int'(e.y));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input int x, input int y);
    int guard;
    guard        = 0;
    sample_valid = 1'b1;
    sample_x     = 10'(x);
    sample_y     = 10'(y);
    while (!sample_ready && guard < 20) begin
      @(negedge clk_30hz);
      guard++;
    end
    if (guard >= 20) check("sample_ready_timeout", 0, 1);
    @(negedge clk_30hz);
    sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(negedge clk_30hz);
    @(negedge clk_30hz);
    RST = 1'b0;
    @(negedge clk_30hz);
  endtask

  task automatic calibrate(input int cx, input int cy);
`ifdef JOYSTICK_CAL_EN
    for (int i = 0; i < 7; i++) send(cx, cy);
    check("cal_done_before_8th", int'(cal_done), 0);
    send(cx, cy);
    check("cal_done_after_8th", int'(cal_done), 1);
    check("x_after_cal", int'(xPosData), 512);
    check("y_after_cal", int'(yPosData), 512);
`else
    check("cal_done_fixed", int'(cal_done), 1);
    if (cx < 0 || cy < 0) check("cal_arg", 0, 1);
`endif
  endtask

  // Four transfers, expecting one update; also checks the OUT bubble and hold.
  task automatic run_avg(input int x, input int y, input int ex, input int ey, input string tag);
    pos_t e;
    for (int i = 0; i < 3; i++) send(x, y);
    e.x = 10'(ex);
    e.y = 10'(ey);
    exp_q.push_back(e);
    send(x, y);
    check({tag, "_ready_in_out"}, int'(sample_ready), 0);
    @(negedge clk_30hz);
    check({tag, "_ready_after_out"}, int'(sample_ready), 1);
    @(negedge clk_30hz);
    check({tag, "_pos_valid_seen"}, exp_q.size(), 0);
    check({tag, "_x_hold"}, int'(xPosData), ex);
    check({tag, "_y_hold"}, int'(yPosData), ey);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef JOYSTICK_CAL_EN
    vecs[0] = '{500, 520,  700, 520,  712, 512};
    vecs[1] = '{500, 500,  560, 500,  512, 512};
    vecs[2] = '{500, 500,  561, 500,  573, 512};
    vecs[3] = '{100, 500, 1023, 500, 1023, 512};
    vecs[4] = '{900, 500,    0, 500,    0, 512};
    vecs[5] = '{500, 520,  300, 400,  312, 392};
`else
    vecs[0] = '{512, 512,  700, 520,  700, 512};
    vecs[1] = '{512, 512,  572, 452,  512, 512};
    vecs[2] = '{512, 512,  573, 451,  573, 451};
    vecs[3] = '{512, 512, 1023,   0, 1023,   0};
    vecs[4] = '{512, 512,    0, 1023,   0, 1023};
    vecs[5] = '{512, 512,  300, 400,  300, 400};
`endif

    RST          = 1'b1;
    sample_valid = 1'b0;
    sample_x     = '0;
    sample_y     = '0;
    btn_raw      = 1'b0;
    repeat (2) @(negedge clk_30hz);
    check("rst_x", int'(xPosData), 512);
    check("rst_y", int'(yPosData), 512);
    check("rst_pos_valid", int'(pos_valid), 0);
    check("rst_fire", int'(fire), 0);
    check("rst_cal_done", int'(cal_done), 0);
    check("rst_ready", int'(sample_ready), 1);
    RST = 1'b0;
    @(negedge clk_30hz);

    for (int v = 0; v < NVEC; v++) begin
      do_reset();
      calibrate(vecs[v].cx, vecs[v].cy);
      run_avg(vecs[v].x, vecs[v].y, vecs[v].ex, vecs[v].ey, $sformatf("vec%0d", v));
    end

    // Reset after two of four transfers; partial sums must not leak into anything later.
    do_reset();
    calibrate(500, 520);
    send(1000, 1000);
    send(1000, 1000);
    RST = 1'b1;
    @(negedge clk_30hz);
    check("midrst_x", int'(xPosData), 512);
    check("midrst_y", int'(yPosData), 512);
    check("midrst_cal_done", int'(cal_done), 0);
    check("midrst_pos_valid", int'(pos_valid), 0);
    @(negedge clk_30hz);
    RST = 1'b0;
    @(negedge clk_30hz);
    check("midrst_no_update", int'(pos_valid), 0);
`ifdef JOYSTICK_CAL_EN
    check("midrst_cal_restart", int'(cal_done), 0);
    calibrate(500, 520);
    run_avg(700, 520, 712, 512, "midrst");
`else
    check("midrst_cal_done_after", int'(cal_done), 1);
    run_avg(700, 520, 700, 512, "midrst");
`endif

    // Two-cycle glitch must not fire.
    btn_raw = 1'b1;
    @(negedge clk_30hz);
    check("fire_glitch_c1", int'(fire), 0);
    @(negedge clk_30hz);
    btn_raw = 1'b0;
    check("fire_glitch_c2", int'(fire), 0);
    repeat (4) begin
      @(negedge clk_30hz);
      check("fire_glitch", int'(fire), 0);
    end

    // Three-cycle press fires once, right after the third high sample.
    btn_raw = 1'b1;
    @(negedge clk_30hz);
    check("fire_press_c1", int'(fire), 0);
    @(negedge clk_30hz);
    check("fire_press_c2", int'(fire), 0);
    @(negedge clk_30hz);
    check("fire_press", int'(fire), 1);
    @(negedge clk_30hz);
    check("fire_single", int'(fire), 0);
    repeat (3) begin
      @(negedge clk_30hz);
      check("fire_held", int'(fire), 0);
    end

    // Release must not fire; a second press fires again.
    btn_raw = 1'b0;
    repeat (5) begin
      @(negedge clk_30hz);
      check("fire_release", int'(fire), 0);
    end
    btn_raw = 1'b1;
    repeat (3) @(negedge clk_30hz);
    check("fire_second_press", int'(fire), 1);
    btn_raw = 1'b0;
    repeat (4) @(negedge clk_30hz);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_joystick_input
`default_nettype wire

// File: doc/joystick_input.md
JOYSTICK_INPUT -- requirements
Module: joystick_input

Interface
REQ-001 SHALL have parameter DEADZONE, default 60: half-width of the neutral band in counts.
REQ-002 SHALL have parameter DEBOUNCE, default 3: consecutive cycles required before the button state changes.
REQ-003 SHALL have port clk_30hz  in  1  system clock; all logic SHALL run on its rising edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports sample_valid  in  1, sample_x  in  10, sample_y  in  10  raw joystick ADC sample offered by the front end.
REQ-006 SHALL have port sample_ready  out  1  block accepts the sample this cycle.
REQ-007 SHALL have port btn_raw  in  1  undebounced fire button.
REQ-008 SHALL have ports xPosData  out  10, yPosData  out  10  conditioned position fed to the engine; 512 means neutral.
REQ-009 SHALL have port pos_valid  out  1  one-cycle pulse when xPosData/yPosData update.
REQ-010 SHALL have port fire  out  1  one-cycle pulse on each debounced press.
REQ-011 SHALL have port cal_done  out  1  centre calibration is complete.

Function
REQ-012 SHALL transfer a sample only in a cycle where sample_valid and sample_ready are both 1; the source holds the sample otherwise.
REQ-013 SHALL implement the states CAL, ACC and OUT; sample_ready SHALL be 1 in CAL and ACC and 0 in OUT.
REQ-014 CAL SHALL sum 8 transfers per axis in 13-bit accumulators.
REQ-015 On the 8th transfer in CAL, the block SHALL set centre = sum>>3, clear the accumulators, set cal_done=1 and enter ACC.
REQ-016 ACC SHALL sum 4 transfers per axis in 12-bit accumulators and SHALL enter OUT on the 4th transfer.
REQ-017 OUT SHALL last 1 cycle and SHALL compute avg = sum>>2 and off = avg - centre as a 12-bit signed value.
REQ-018 In OUT, the result SHALL be 512 if |off| <= DEADZONE, otherwise 512+off clamped to the range 0..1023.
REQ-019 In OUT, the block SHALL register the result into xPosData/yPosData, clear the accumulators and return to ACC.
REQ-020 New xPosData/yPosData SHALL be visible in the cycle after OUT; pos_valid SHALL be 1 in exactly that cycle.
REQ-021 xPosData/yPosData SHALL hold their value between updates.
REQ-022 The block SHALL keep a debounced button state and a counter of consecutive cycles in which btn_raw differs from that state.
REQ-023 The counter SHALL reset to 0 whenever btn_raw equals the debounced state.
REQ-024 When the counter reaches DEBOUNCE, the debounced state SHALL toggle and the counter SHALL clear.
REQ-025 fire SHALL be 1 for exactly the cycle after a 0->1 toggle of the debounced state.
REQ-026 Button debouncing SHALL be independent of the sample FSM and SHALL operate in every state.

Reset
REQ-027 RST SHALL set xPosData=512, yPosData=512, pos_valid=0, fire=0, cal_done=0 and sample_ready=1.
REQ-028 RST SHALL clear the accumulators, the transfer counter and the debounce counter, and SHALL set the debounced state to 0 and the state to CAL.
REQ-029 RST asserted mid-accumulation or in OUT SHALL discard the partial sums, and no pos_valid SHALL follow.
REQ-030 RST SHALL take priority over a simultaneous transfer; that sample SHALL be dropped.

Configuration
REQ-031 Macro JOYSTICK_CAL_EN SHALL control calibration.
REQ-032 With JOYSTICK_CAL_EN defined, the block SHALL behave as specified above.
REQ-033 Without JOYSTICK_CAL_EN, the CAL state SHALL be absent and centre SHALL be fixed at 512.
REQ-034 Without JOYSTICK_CAL_EN, reset SHALL enter ACC, and cal_done SHALL be 1 from the first cycle after RST deasserts.

Structure
REQ-035 Package joystick_pkg SHALL hold the state enum and the constants NEUTRAL=512, CAL_SAMPLES=8, AVG_SAMPLES=4 and the default DEADZONE and DEBOUNCE values.
REQ-036 Sub-module joystick_axis SHALL contain the per-axis accumulator, centre register, offset, deadzone and clamp logic, instantiated twice (x, y).
REQ-037 The FSM and the debouncer SHALL reside in joystick_input.

Verification
REQ-038 Reset, then 8 transfers of (500,520) -> cal_done=1 the cycle after the 8th transfer; x/y outputs remain 512.
REQ-039 Centre (500,520), then 4 transfers of (700,520) -> sample_ready=0 for 1 cycle, then xPosData=712, yPosData=512 with pos_valid=1 for 1 cycle.
REQ-040 Centre (500,500), 4 transfers of x=560 -> xPosData=512; 4 transfers of x=561 -> xPosData=573.
REQ-041 Clamping: centre x=100 with x=1023 -> xPosData=1023; centre x=900 with x=0 -> xPosData=0.
REQ-042 Debounce: btn_raw high for 2 cycles then low -> fire never asserts; high for 3 cycles -> fire=1 for exactly 1 cycle, after the 3rd high cycle.
REQ-043 Mid-operation reset: RST after 2 of 4 ACC transfers -> outputs 512, cal_done=0, no pos_valid, calibration restarts (both macro settings covered).
